fp_to_fixed_conv: RTL and testbench

- Sequential IEEE-754 single-precision to signed fixed-point converter.
- Sits directly upstream of the CORDIC sin(x) core. It converts the float angle operand into the core's signed Q(W-FRAC).FRAC format.
- Uses an iterative 1-bit-per-cycle shifter with valid/ready handshakes on both sides.
- Flags out-of-range operands so downstream range logic can act on them.

---
 rtl/fp_pkg.sv | 36 +++
 rtl/fp_classify.sv | 48 ++++
 rtl/fp_to_fixed_conv.sv | 130 +++++++++++++
 tb/tb_fp_to_fixed_conv.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field constants, FSM state and operand
// class enumerations for the float-to-fixed front end of the CORDIC path.
package fp_pkg;

    // Bit positions inside an IEEE-754 single.
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int FRAC_MSB = 22;

    localparam int          EXP_BIAS    = 127;
    localparam logic [7:0]  EXP_SPECIAL = 8'hFF;
    localparam int          MANT_W      = 24;

    // Width of the shift counter; |L| never exceeds MANT_W on the normal path.
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SIGN,
        OUT
    } conv_state_t;

    typedef enum logic [1:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_OVF
    } fp_class_t;

    // Mantissa with the hidden leading one restored.
    function automatic logic [MANT_W-1:0] get_mant(input logic [31:0] f);
        return {1'b1, f[FRAC_MSB:0]};
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier: decides whether a single-precision value
// saturates, collapses to zero or takes the normal shift path, and reports the
// shift direction and distance |L| that aligns the mantissa to Q(W-FRAC).FRAC.
module fp_classify
    import fp_pkg::*;
#(
    parameter int W    = 32,
    parameter int FRAC = 30
) (
    input  logic [31:0]      in_data,
    output fp_class_t        cls,
    output logic             shift_left,
    output logic [CNT_W-1:0] shift_amt
);

    // L = E + L_OFS is the left-shift distance of the 24-bit mantissa.
    localparam int L_OFS   = FRAC - (MANT_W - 1) - EXP_BIAS;
    // Any exponent at or above this one is out of range (includes -2.0).
    localparam int OVF_EXP = EXP_BIAS + W - 1 - FRAC;

    localparam logic signed [11:0] L_OFS_S = 12'(L_OFS);
    localparam logic signed [11:0] L_MIN_S = 12'(-MANT_W);

    logic [7:0]         exp_field;
    logic signed [11:0] l_val;

    assign exp_field = in_data[EXP_MSB:EXP_LSB];
    assign l_val     = $signed({4'b0000, exp_field}) + L_OFS_S;

    // Priority classification plus shift direction/magnitude.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        cls        = CLS_NORMAL;
        shift_left = ~l_val[11];
        shift_amt  = l_val[11] ? CNT_W'(-l_val) : CNT_W'(l_val);

        if (exp_field == EXP_SPECIAL) begin
            cls = CLS_OVF;
        end else if (exp_field == 8'd0) begin
            cls = CLS_ZERO;
        end else if (int'(exp_field) >= OVF_EXP) begin
            cls = CLS_OVF;
        end else if (l_val < L_MIN_S) begin
            cls = CLS_ZERO;
        end
    end

endmodule

// File: rtl/fp_to_fixed_conv.sv
// Iterative IEEE-754 single to signed Q(W-FRAC).FRAC converter. The mantissa
// is aligned one bit per cycle, then the sign is applied and the result is
// held behind a valid/ready handshake until the consumer takes it.
module fp_to_fixed_conv
    import fp_pkg::*;
#(
    parameter int W    = 32,
    parameter int FRAC = 30
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_ovf,
    output logic         out_zero
);

    localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

    conv_state_t      state;
    logic [W-1:0]     acc;
    logic [CNT_W-1:0] cnt;
    logic             sign_q;
    logic             left_q;
    logic             special_q;
    logic             ovf_q;
    logic             zero_q;

    fp_class_t        cls;
    logic             shift_left;
    logic [CNT_W-1:0] shift_amt;

    fp_classify #(
        .W    (W),
        .FRAC (FRAC)
    ) u_classify (
        .in_data    (in_data),
        .cls        (cls),
        .shift_left (shift_left),
        .shift_amt  (shift_amt)
    );

    assign in_ready = (state == IDLE);

    // Conversion FSM: accept/classify, shift, apply sign, present result.
    always_ff @(posedge clk) begin
        // NOTE: all state is assigned with <= so every register samples the
        // pre-edge values, regardless of statement order.
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            sign_q    <= 1'b0;
            left_q    <= 1'b0;
            special_q <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q <= in_data[SIGN_BIT];
                        left_q <= shift_left;
                        cnt    <= shift_amt;
                        unique case (cls)
                            CLS_OVF: begin
                                acc       <= in_data[SIGN_BIT] ? SAT_NEG : SAT_POS;
                                special_q <= 1'b1;
                                ovf_q     <= 1'b1;
                                zero_q    <= 1'b0;
                                state     <= SIGN;
                            end
                            CLS_ZERO: begin
                                acc       <= '0;
                                special_q <= 1'b1;
                                ovf_q     <= 1'b0;
                                zero_q    <= 1'b1;
                                state     <= SIGN;
                            end
                            default: begin
                                acc       <= W'(get_mant(in_data));
                                special_q <= 1'b0;
                                ovf_q     <= 1'b0;
                                zero_q    <= 1'b0;
                                state     <= (shift_amt == '0) ? SIGN : SHIFT;
                            end
                        endcase
                    end
                end

                SHIFT: begin
                    acc   <= left_q ? (acc << 1) : (acc >> 1);
                    cnt   <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= SIGN;
                    end
                end

                SIGN: begin
                    // Magnitude was truncated during the shift; negate after.
                    out_data  <= (sign_q && !special_q) ? (~acc + 1'b1) : acc;
                    out_ovf   <= ovf_q;
                    // A normal operand whose bits all fell off is an underflow.
                    out_zero  <= zero_q || (!special_q && (acc == '0));
                    out_valid <= 1'b1;
                    state     <= OUT;
                end

                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_to_fixed_conv.sv
// Self-checking bench for fp_to_fixed_conv: directed vector table, random
// operands against an arithmetic reference model, backpressure and reset
// sequences.
module tb_fp_to_fixed_conv;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_zero;

    int n_vec = 0;
    int n_err = 0;

    fp_to_fixed_conv #(.W(32), .FRAC(30)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] din;
        logic [31:0] data;
        logic        ovf;
        logic        zero;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: value = mant * 2^(E-150); fixed = trunc(|value| * 2^30), signed.
    task automatic model(input logic [31:0] f, output logic [31:0] d,
                         output logic ovf, output logic zero, output int lat);
        int                 e;
        int                 e2;
        longint unsigned    mant;
        longint unsigned    mag;
        logic               s;
        e    = int'(f[30:23]);
        s    = f[31];
        mant = longint'({1'b1, f[22:0]});
        ovf  = 1'b0;
        zero = 1'b0;
        d    = 32'h0;
        lat  = 2;
        if (e == 255) begin
            ovf = 1'b1;
            d   = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (e == 0) begin
            zero = 1'b1;
        end else begin
            e2 = e - 150 + 30;
            if (e2 > 40)       mag = 64'h1 << 40;
            else if (e2 >= 0)  mag = mant << e2;
            else if (e2 < -40) mag = 64'h0;
            else               mag = mant >> (-e2);
            if (mag >= (64'h1 << 31)) begin
                ovf = 1'b1;
                d   = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                d    = s ? 32'(-mag) : 32'(mag);
                zero = (mag == 0);
                if (e2 >= -24) lat = (e2 < 0 ? -e2 : e2) + 2;
            end
        end
    endtask

    // One complete conversion; latency counts edges from the accept edge
    // (inclusive) to the edge that raises out_valid.
    task automatic run_conv(input logic [31:0] din, input int stall,
                            output logic [31:0] d, output logic ovf,
                            output logic zero, output int lat);
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        in_data   = din;
        check("in_ready_idle", {31'b0, in_ready}, 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) check("timeout", 32'h0, 32'h1);
        d    = out_data;
        ovf  = out_ovf;
        zero = out_zero;
        check("in_ready_busy", {31'b0, in_ready}, 32'h0);
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                check("stall_valid", {31'b0, out_valid}, 32'h1);
                check("stall_data", out_data, d);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("valid_drop", {31'b0, out_valid}, 32'h0);
        check("in_ready_after", {31'b0, in_ready}, 32'h1);
    endtask

    logic [31:0] got_d, exp_d, held;
    logic        got_o, got_z, exp_o, exp_z;
    int          got_l, exp_l;
    logic        seen;

    initial begin
        vecs[0]  = '{32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 9};
        vecs[1]  = '{32'hBFC0_0000, 32'hA000_0000, 1'b0, 1'b0, 9};
        vecs[2]  = '{32'h3F49_0FDB, 32'h3243_F6C0, 1'b0, 1'b0, 8};
        vecs[3]  = '{32'h4000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2};
        vecs[4]  = '{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 2};
        vecs[5]  = '{32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2};
        vecs[6]  = '{32'h2EDB_E6FF, 32'h0000_0000, 1'b0, 1'b1, 2};
        vecs[7]  = '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1, 2};
        vecs[8]  = '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 2};
        vecs[9]  = '{32'hC000_0000, 32'h8000_0000, 1'b1, 1'b0, 2};
        vecs[10] = '{32'h3F00_0000, 32'h2000_0000, 1'b0, 1'b0, 8};
        vecs[11] = '{32'h3FFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 9};
        vecs[12] = '{32'h3000_0000, 32'h0000_0000, 1'b0, 1'b1, 26};
        vecs[13] = '{32'h3080_0000, 32'h0000_0001, 1'b0, 1'b0, 25};
        vecs[14] = '{32'hB080_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 25};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_flags", {30'b0, out_ovf, out_zero}, 32'h0);
        check("rst_in_ready", {31'b0, in_ready}, 32'h1);

        // Directed table.
        for (int i = 0; i < 15; i++) begin
            run_conv(vecs[i].din, 0, got_d, got_o, got_z, got_l);
            check($sformatf("tbl%0d_data", i), got_d, vecs[i].data);
            check($sformatf("tbl%0d_ovf", i), {31'b0, got_o}, {31'b0, vecs[i].ovf});
            check($sformatf("tbl%0d_zero", i), {31'b0, got_z}, {31'b0, vecs[i].zero});
            check($sformatf("tbl%0d_lat", i), got_l, vecs[i].lat);
        end

        // Randomized operands versus the arithmetic model, with random stalls.
        for (int i = 0; i < 80; i++) begin
            logic [31:0] f;
            int          e;
            int          st;
            e  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(90, 135))
                                             : int'($urandom_range(0, 255));
            f  = {1'($urandom), 8'(e), 23'($urandom)};
            st = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 3)) : 0;
            model(f, exp_d, exp_o, exp_z, exp_l);
            run_conv(f, st, got_d, got_o, got_z, got_l);
            check($sformatf("rnd_%h_data", f), got_d, exp_d);
            check($sformatf("rnd_%h_flags", f), {30'b0, got_o, got_z}, {30'b0, exp_o, exp_z});
            check($sformatf("rnd_%h_lat", f), got_l, exp_l);
        end

        // Backpressure on 0.5, then a queued operand accepted right after release.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h3F00_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        got_l = 1;
        while (!out_valid && got_l < 64) begin
            @(posedge clk); #1;
            got_l++;
        end
        check("bp_lat", got_l, 8);
        check("bp_data", out_data, 32'h2000_0000);
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", {31'b0, out_valid}, 32'h1);
            check("bp_hold_data", out_data, held);
            check("bp_hold_flags", {30'b0, out_ovf, out_zero}, 32'h0);
            check("bp_in_ready", {31'b0, in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hBF80_0000;
        @(posedge clk); #1;
        check("bp_release_ready", {31'b0, in_ready}, 32'h1);
        check("bp_release_valid", {31'b0, out_valid}, 32'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_queued_accept", {31'b0, in_ready}, 32'h0);
        got_l = 1;
        while (!out_valid && got_l < 64) begin
            @(posedge clk); #1;
            got_l++;
        end
        check("bp_queued_data", out_data, 32'hC000_0000);
        check("bp_queued_lat", got_l, 9);
        @(posedge clk); #1;
        check("bp_queued_drop", {31'b0, out_valid}, 32'h0);

        // Reset in the middle of shifting 1.0.
        in_valid = 1'b1;
        in_data  = 32'h3F80_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_valid", {31'b0, out_valid}, 32'h0);
        check("mid_rst_ready", {31'b0, in_ready}, 32'h1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen = 1'b1;
        end
        check("mid_rst_no_stale", {31'b0, seen}, 32'h0);
        run_conv(32'h3F00_0000, 0, got_d, got_o, got_z, got_l);
        check("post_rst_data", got_d, 32'h2000_0000);
        check("post_rst_flags", {30'b0, got_o, got_z}, 32'h0);
        check("post_rst_lat", got_l, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
